sync_priority_encoder: RTL and testbench

- Registered 8-to-3 priority encoder in 74x148 style, with active-low request lines, active-low enable and active-low code outputs.
- It is the encoding counterpart to the team's 2-to-4 / 3-to-8 active-low decoders. It turns asynchronous button or board request lines into a stable code.
- The code is presented under a VALID/ACK handshake to the downstream consumer, typically a decoder or display driver.
- Each request assertion is latched as a sticky event, so short pulses are not lost.

---
 rtl/enc_pkg.sv | 25 ++
 rtl/sync_edge_detect.sv | 38 +++
 rtl/sync_priority_encoder.sv | 106 ++++++++++
 tb/tb_sync_priority_encoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the synchronous priority encoder.
// Holds the FSM state type, the request/code widths and the
// highest-set-bit helper used to pick the presented request.
package enc_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_e;

  // Highest set index of vec; returns 0 for an all-zero vector, so the
  // caller must qualify with vec != 0.
  function automatic logic [CODE_W-1:0] prio8(input logic [N_REQ-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with falling-edge detect for active-low lines.
// Ports:
//   clk   - sampling clock
//   rst_n - async active-low reset; every flop presets to 1 (line inactive)
//   d     - asynchronous active-low inputs
//   s     - synchronized copy of d
//   fall  - one-cycle pulse per bit when s goes 1 -> 0
module sync_edge_detect #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '1;
      prev <= '1;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign s    = chain[STAGES-1];
  // Presetting prev and the chain to 1 means a line already low at reset
  // release still produces exactly one event once it propagates.
  assign fall = prev & ~s;

endmodule

// File: rtl/sync_priority_encoder.sv
// Registered 8-to-3 priority encoder (74x148 style) with sticky request
// events and a VALID/ACK handshake toward the consumer.
// Ports:
//   CLK     - system clock
//   RESET_N - async active-low reset
//   EI_L    - active-low enable, gates IDLE->PRESENT only
//   I_L     - async active-low requests, bit 7 highest priority
//   ACK     - consumer accepts the presented code (used only in PRESENT)
//   A_L     - active-low code of the presented request
//   GS_L    - active-low group select, low while VALID
//   VALID   - a code is presented and held stable
//   EO_L    - active-low cascade enable-out
//   PEND    - pending event vector
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing presented; picks highest pending event when enabled
// PRESENT | idx frozen and driven on A_L until ACK clears its event
module sync_priority_encoder
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              EI_L,
  input  logic [N_REQ-1:0]  I_L,
  input  logic              ACK,
  output logic [CODE_W-1:0] A_L,
  output logic              GS_L,
  output logic              VALID,
  output logic              EO_L,
  output logic [N_REQ-1:0]  PEND
);

  logic [N_REQ-1:0]  s_req;
  logic [N_REQ-1:0]  fall;
  logic [N_REQ-1:0]  pend_q;
  logic [N_REQ-1:0]  pend_next;
  logic [N_REQ-1:0]  clr;
  logic [CODE_W-1:0] idx_q;
  logic [CODE_W-1:0] idx_next;
  logic              eo_l_q;
  enc_state_e        state_q;
  enc_state_e        state_next;

  sync_edge_detect #(
    .WIDTH  (N_REQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (I_L),
    .s     (s_req),
    .fall  (fall)
  );

  always_comb begin
    state_next = state_q;
    idx_next   = idx_q;
    clr        = '0;
    case (state_q)
      IDLE: begin
        if (!EI_L && (pend_q != '0)) begin
          idx_next   = prio8(pend_q);
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (ACK) begin
          clr[idx_q] = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A new fall on the bit being acknowledged wins over the clear.
    pend_next = (pend_q & ~clr) | fall;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
      eo_l_q  <= 1'b1;
    end else begin
      state_q <= state_next;
      idx_q   <= idx_next;
      pend_q  <= pend_next;
      eo_l_q  <= ~(~EI_L & (pend_next == '0) & (state_next == IDLE));
    end
  end

  // Outputs are decoded from registered state only.
  assign VALID = (state_q == PRESENT);
  assign GS_L  = ~VALID;
  assign A_L   = VALID ? ~idx_q : '1;
  assign EO_L  = eo_l_q;
  assign PEND  = pend_q;

  // s_req is kept for visibility; only the edge pulses drive the logic.
  logic unused_s;
  assign unused_s = ^s_req;

endmodule

// File: tb/tb_sync_priority_encoder.sv
module tb_sync_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic       ei_l;
  logic [7:0] i_l;
  logic       ack;
  logic [2:0] a_l;
  logic       gs_l;
  logic       valid;
  logic       eo_l;
  logic [7:0] pend;

  int n_chk;
  int n_fail;

  sync_priority_encoder #(.SYNC_STAGES(2)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .EI_L    (ei_l),
    .I_L     (i_l),
    .ACK     (ack),
    .A_L     (a_l),
    .GS_L    (gs_l),
    .VALID   (valid),
    .EO_L    (eo_l),
    .PEND    (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pat;       // I_L value pulsed for two clocks
    logic [7:0] exp_pend;  // PEND two edges after first sample
    logic [2:0] exp_a_l;   // first presented code
    int         exp_cnt;   // number of codes before PEND drains
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int cnt;
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{8'hFE, 8'h01, 3'b111, 1};
    vecs[1] = '{8'h7F, 8'h80, 3'b000, 1};
    vecs[2] = '{8'hDF, 8'h20, 3'b010, 1};
    vecs[3] = '{8'hAA, 8'h55, 3'b001, 4};
    vecs[4] = '{8'h0F, 8'hF0, 3'b000, 4};
    vecs[5] = '{8'hEF, 8'h10, 3'b011, 1};
    vecs[6] = '{8'hF5, 8'h0A, 3'b100, 2};

    // Reset
    rst_n = 1'b0;
    ei_l  = 1'b0;
    i_l   = 8'h00;
    ack   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_l",  {5'b0, a_l}, 8'h07);
    chk("rst_gs_l", {7'b0, gs_l}, 8'h01);
    chk("rst_valid", {7'b0, valid}, 8'h00);
    chk("rst_eo_l", {7'b0, eo_l}, 8'h01);
    chk("rst_pend", pend, 8'h00);
    i_l   = 8'hFF;
    rst_n = 1'b1;
    step();
    step();
    chk("rel_eo_l", {7'b0, eo_l}, 8'h00);
    chk("rel_valid", {7'b0, valid}, 8'h00);

    // Single request held low, latency
    i_l = 8'hDF;
    step(); step();
    chk("lat_pend_k1", pend, 8'h00);
    step();
    chk("lat_pend_k2", pend, 8'h20);
    chk("lat_valid_k2", {7'b0, valid}, 8'h00);
    step();
    chk("lat_valid_k3", {7'b0, valid}, 8'h01);
    chk("lat_a_l", {5'b0, a_l}, 8'h02);
    chk("lat_gs_l", {7'b0, gs_l}, 8'h00);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_valid", {7'b0, valid}, 8'h00);
    chk("ack_pend", pend, 8'h00);
    chk("ack_eo_l", {7'b0, eo_l}, 8'h00);
    repeat (5) step();
    chk("held_no_reevent_pend", pend, 8'h00);
    chk("held_no_reevent_valid", {7'b0, valid}, 8'h00);
    i_l = 8'hFF;
    repeat (3) step();

    // Table-driven single pulses
    for (int v = 0; v < 7; v++) begin
      i_l = vecs[v].pat;
      step(); step();
      i_l = 8'hFF;
      step();
      chk($sformatf("tbl%0d_pend", v), pend, vecs[v].exp_pend);
      step();
      chk($sformatf("tbl%0d_valid", v), {7'b0, valid}, 8'h01);
      chk($sformatf("tbl%0d_a_l", v), {5'b0, a_l}, {5'b0, vecs[v].exp_a_l});
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
        if (!valid && pend == 8'h00) break;
        if (valid) begin
          ack = 1'b1; step(); ack = 1'b0;
          cnt++;
        end else begin
          step();
        end
      end
      chk($sformatf("tbl%0d_cnt", v), 8'(cnt), 8'(vecs[v].exp_cnt));
      chk($sformatf("tbl%0d_drain", v), pend, 8'h00);
      step();
    end

    // Priority and freeze
    i_l = 8'hBB;
    step(); step();
    i_l = 8'hFF;
    step();
    chk("pri_pend", pend, 8'h44);
    step();
    chk("pri_a_l_first", {5'b0, a_l}, 8'h01);
    i_l = 8'h7F;
    step(); step();
    i_l = 8'hFF;
    step(); step();
    chk("frz_pend", pend, 8'hC4);
    chk("frz_a_l", {5'b0, a_l}, 8'h01);
    ack = 1'b1; step(); ack = 1'b0;
    chk("pri_ack1_valid", {7'b0, valid}, 8'h00);
    chk("pri_ack1_pend", pend, 8'h84);
    step();
    chk("pri_a_l_second", {5'b0, a_l}, 8'h00);
    ack = 1'b1; step(); ack = 1'b0;
    chk("pri_ack2_pend", pend, 8'h04);
    step();
    chk("pri_a_l_third", {5'b0, a_l}, 8'h05);
    ack = 1'b1; step(); ack = 1'b0;
    chk("pri_ack3_pend", pend, 8'h00);
    step();

    // Short pulse captured while disabled
    ei_l = 1'b1;
    i_l  = 8'hFE;
    step(); step();
    i_l = 8'hFF;
    repeat (3) step();
    chk("dis_pend", pend, 8'h01);
    chk("dis_valid", {7'b0, valid}, 8'h00);
    chk("dis_eo_l", {7'b0, eo_l}, 8'h01);
    ei_l = 1'b0;
    step();
    chk("en_valid", {7'b0, valid}, 8'h01);
    chk("en_a_l", {5'b0, a_l}, 8'h07);
    ack = 1'b1; step(); ack = 1'b0;
    chk("en_ack_pend", pend, 8'h00);
    step();

    // Set/clear collision on the presented bit
    i_l = 8'hF7;
    repeat (4) step();
    chk("col_valid", {7'b0, valid}, 8'h01);
    chk("col_a_l", {5'b0, a_l}, 8'h04);
    i_l = 8'hFF;
    repeat (3) step();
    i_l = 8'hF7;
    step(); step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("col_idle_valid", {7'b0, valid}, 8'h00);
    chk("col_pend_kept", pend, 8'h08);
    step();
    chk("col_revalid", {7'b0, valid}, 8'h01);
    chk("col_re_a_l", {5'b0, a_l}, 8'h04);
    i_l = 8'hFF;
    ack = 1'b1; step(); ack = 1'b0;
    chk("col_final_pend", pend, 8'h00);
    repeat (3) step();

    // Reset mid-presentation
    i_l = 8'h7E;
    step(); step();
    i_l = 8'hFF;
    step(); step();
    chk("mid_valid", {7'b0, valid}, 8'h01);
    chk("mid_pend", pend, 8'h81);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {7'b0, valid}, 8'h00);
    chk("mid_rst_pend", pend, 8'h00);
    chk("mid_rst_a_l", {5'b0, a_l}, 8'h07);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_rst_valid", {7'b0, valid}, 8'h00);
    chk("post_rst_pend", pend, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
